// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared slot map, square fields, home positions and FSM encoding
package chess_pkg;

    localparam int NUM_SLOTS = 16;
    localparam int SQ_W      = 6;
    localparam int LV_W      = NUM_SLOTS * SQ_W;

    localparam int ROW_MSB = 5;
    localparam int ROW_LSB = 3;
    localparam int COL_MSB = 2;
    localparam int COL_LSB = 0;

    localparam int SLOT_KING    = 0;
    localparam int SLOT_QUEEN   = 1;
    localparam int SLOT_BISHOP0 = 2;
    localparam int SLOT_BISHOP1 = 3;
    localparam int SLOT_KNIGHT0 = 4;
    localparam int SLOT_KNIGHT1 = 5;
    localparam int SLOT_ROOK0   = 6;
    localparam int SLOT_ROOK1   = 7;
    localparam int SLOT_PAWN0   = 8;

    typedef enum logic [2:0] {
        ST_SELECT,
        ST_HELD,
        ST_ARMED,
        ST_COMMIT,
        ST_DONE
    } state_t;

    // Home layout for one side: back rank pieces on back_row, pawn 8+c on (pawn_row, c).
    function automatic logic [LV_W-1:0] home_locations(input logic [2:0] back_row,
                                                        input logic [2:0] pawn_row);
        logic [LV_W-1:0] lv;
        lv = '0;
        lv[SLOT_KING*SQ_W    +: SQ_W] = {back_row, 3'd4};
        lv[SLOT_QUEEN*SQ_W   +: SQ_W] = {back_row, 3'd3};
        lv[SLOT_BISHOP0*SQ_W +: SQ_W] = {back_row, 3'd2};
        lv[SLOT_BISHOP1*SQ_W +: SQ_W] = {back_row, 3'd5};
        lv[SLOT_KNIGHT0*SQ_W +: SQ_W] = {back_row, 3'd1};
        lv[SLOT_KNIGHT1*SQ_W +: SQ_W] = {back_row, 3'd6};
        lv[SLOT_ROOK0*SQ_W   +: SQ_W] = {back_row, 3'd0};
        lv[SLOT_ROOK1*SQ_W   +: SQ_W] = {back_row, 3'd7};
        for (int c = 0; c < 8; c++) begin
            lv[(SLOT_PAWN0 + c)*SQ_W +: SQ_W] = {pawn_row, 3'(c)};
        end
        return lv;
    endfunction

    localparam logic [LV_W-1:0] LVW_RESET    = home_locations(3'd0, 3'd1);
    localparam logic [LV_W-1:0] LVB_RESET    = home_locations(3'd7, 3'd6);
    localparam logic [SQ_W-1:0] CURSOR_RESET = 6'b000_100;

endpackage

// File: rtl/piece_finder.sv
// rtl/piece_finder.sv - finds the lowest-index alive slot sitting on a square
module piece_finder
    import chess_pkg::*;
(
    input  logic [LV_W-1:0]      locations,
    input  logic [NUM_SLOTS-1:0] alive,
    input  logic [SQ_W-1:0]      square,
    output logic                 hit,
    output logic [3:0]           slot
);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit  = 1'b0;
        slot = 4'd0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (alive[k] && (locations[k*SQ_W +: SQ_W] == square)) begin
                hit  = 1'b1;
                slot = 4'(k);
            end
        end
    end

endmodule

// File: rtl/move_controller.sv
// rtl/move_controller.sv - cursor, piece pick/place FSM and board state for two sides
module move_controller
    import chess_pkg::*;
#(
    parameter int BOARD_MAX = 7
) (
    input  logic                 clk12,
    input  logic                 reset,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_enter,
    input  logic                 btn_esc,
    input  logic                 btn_confirm,
    output logic [SQ_W-1:0]      cursor,
    output logic                 enter_pressed,
    output logic                 confirm_pressed,
    output logic                 player,
    output logic [LV_W-1:0]      lvw,
    output logic [LV_W-1:0]      lvb,
    output logic [NUM_SLOTS-1:0] avw,
    output logic [NUM_SLOTS-1:0] avb,
    output logic                 move_done,
    output logic                 capture,
    output logic                 game_over
);

    localparam logic [2:0] MAX_IDX = 3'(BOARD_MAX);

    state_t state, state_next;

    logic [3:0]      held_slot;
    logic [SQ_W-1:0] src_sq, dst_sq;

    logic [LV_W-1:0]      own_lv, opp_lv;
    logic [NUM_SLOTS-1:0] own_av, opp_av;
    logic                 own_hit, opp_hit, king_hit;
    logic [3:0]           own_slot, opp_slot;

    logic act_esc, act_confirm, act_enter, act_dir;
    logic steer, latch_src, latch_dst, commit;
    logic [2:0] row_next, col_next;
    logic [6:0] held_base;

    assign own_lv = player ? lvw : lvb;
    assign own_av = player ? avw : avb;
    assign opp_lv = player ? lvb : lvw;
    assign opp_av = player ? avb : avw;

    piece_finder u_own_finder (
        .locations (own_lv),
        .alive     (own_av),
        .square    (cursor),
        .hit       (own_hit),
        .slot      (own_slot)
    );

    // The opponent lookup only matters during COMMIT, where the destination is the target.
    piece_finder u_opp_finder (
        .locations (opp_lv),
        .alive     (opp_av),
        .square    (dst_sq),
        .hit       (opp_hit),
        .slot      (opp_slot)
    );

    assign king_hit = opp_hit && (opp_slot == 4'(SLOT_KING));

    assign act_esc     = btn_esc;
    assign act_confirm = btn_confirm & ~btn_esc;
    assign act_enter   = btn_enter & ~btn_esc & ~btn_confirm;
    assign act_dir     = ~(btn_esc | btn_confirm | btn_enter);

    always_ff @(posedge clk12) begin
        if (reset) begin
            state <= ST_SELECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        steer      = 1'b0;
        latch_src  = 1'b0;
        latch_dst  = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_SELECT: begin
                steer = act_dir;
                if (act_enter && own_hit) begin
                    state_next = ST_HELD;
                    latch_src  = 1'b1;
                end
            end
            ST_HELD: begin
                steer = act_dir;
                if (act_esc) begin
                    state_next = ST_SELECT;
                end else if (act_enter && (cursor != src_sq) && !own_hit) begin
                    state_next = ST_ARMED;
                    latch_dst  = 1'b1;
                end
            end
            ST_ARMED: begin
                if (act_esc) begin
                    state_next = ST_HELD;
                end else if (act_confirm) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit     = 1'b1;
                state_next = king_hit ? ST_DONE : ST_SELECT;
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_SELECT;
            end
        endcase
    end

    always_comb begin
        row_next = cursor[ROW_MSB:ROW_LSB];
        col_next = cursor[COL_MSB:COL_LSB];
        if (steer) begin
            if (btn_up && (row_next < MAX_IDX)) begin
                row_next = row_next + 3'd1;
            end else if (btn_down && (row_next != 3'd0)) begin
                row_next = row_next - 3'd1;
            end
            if (btn_right && (col_next < MAX_IDX)) begin
                col_next = col_next + 3'd1;
            end else if (btn_left && (col_next != 3'd0)) begin
                col_next = col_next - 3'd1;
            end
        end
    end

    assign held_base = 7'(held_slot) * 7'd6;

    always_ff @(posedge clk12) begin
        if (reset) begin
            cursor          <= CURSOR_RESET;
            player          <= 1'b1;
            lvw             <= LVW_RESET;
            lvb             <= LVB_RESET;
            avw             <= '1;
            avb             <= '1;
            held_slot       <= 4'd0;
            src_sq          <= '0;
            dst_sq          <= '0;
            enter_pressed   <= 1'b0;
            confirm_pressed <= 1'b0;
            move_done       <= 1'b0;
            capture         <= 1'b0;
            game_over       <= 1'b0;
        end else begin
            cursor          <= {row_next, col_next};
            enter_pressed   <= (state_next == ST_HELD) || (state_next == ST_ARMED);
            confirm_pressed <= (state_next == ST_ARMED) || (state_next == ST_COMMIT);
            move_done       <= 1'b0;
            capture         <= 1'b0;
            if (latch_src) begin
                held_slot <= own_slot;
                src_sq    <= cursor;
            end
            if (latch_dst) begin
                dst_sq <= cursor;
            end
            if (commit) begin
                if (player) begin
                    lvw[held_base +: SQ_W] <= dst_sq;
                end else begin
                    lvb[held_base +: SQ_W] <= dst_sq;
                end
                if (opp_hit) begin
                    if (player) begin
                        avb[opp_slot] <= 1'b0;
                    end else begin
                        avw[opp_slot] <= 1'b0;
                    end
                    capture <= 1'b1;
                end
                move_done <= 1'b1;
                // Losing the king ends the game with the winner still shown as the side to move.
                if (king_hit) begin
                    game_over <= 1'b1;
                end else begin
                    player <= ~player;
                end
            end
        end
    end

endmodule
